sme_driver: RTL and testbench
=============================

Name: sme_driver

Overview:
- Host-side transmitter for the string-matching engine's character-stream protocol.
- Holds a string buffer (up to 32 chars) and a pattern buffer (up to 8 chars), loaded by a simple write port.
- On command, serializes the buffers onto chardata/isstring/ispattern, waits for the engine's valid pulse, then captures match/match_index and returns them to the host with a one-cycle done pulse.

Parameters:
STR_MAX, 32, string buffer depth in chars; match_index range 0..31.
PAT_MAX, 8, pattern buffer depth in chars.
TIMEOUT_CYC, 1023, watchdog limit in cycles; used only with TIMEOUT_EN.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
cfg_we  input  1  buffer write strobe
cfg_sel  input  1  0 = string buffer, 1 = pattern buffer
cfg_addr  input  5  char address; pattern buffer uses bits [2:0]
cfg_data  input  8  char to write
str_len  input  6  string length, legal 1..32, sampled at start
pat_len  input  4  pattern length, legal 1..8, sampled at start
send_str  input  1  resend string before pattern, sampled at start
start  input  1  one-cycle command pulse
busy  output  1  job in progress
chardata  output  8  char to engine
isstring  output  1  chardata is a string char
ispattern  output  1  chardata is a pattern char
valid  input  1  engine result strobe
match  input  1  engine match flag
match_index  input  5  engine match position
done  output  1  one-cycle result strobe
res_match  output  1  captured match
res_index  output  5  captured index, 0 when no match
timeout  output  1  watchdog fired; qualifies done

Behaviour:
- Reset values: all outputs 0; state IDLE; str_sent = 0. Buffer contents are not reset.
- Outputs are registered. isstring and ispattern are never high together. chardata = 0 whenever both are low.
- cfg_we is honoured only in IDLE; it is ignored while busy.
- FSM states: IDLE, SEND_STR, SEND_PAT, WAIT, DONE.
- IDLE:
  - Accepts start only when str_len is 1..STR_MAX and pat_len is 1..PAT_MAX; otherwise start is ignored with no response.
  - On accept: latch lengths; busy = 1 from the next cycle.
  - Go to SEND_STR if send_str = 1 or str_sent = 0; otherwise go to SEND_PAT.
- SEND_STR:
  - One char per cycle, addresses 0..str_len-1, isstring = 1.
  - After the last char, go directly to SEND_PAT with no gap cycle; set str_sent = 1.
- SEND_PAT:
  - One char per cycle, addresses 0..pat_len-1, ispattern = 1.
  - After the last char, go to WAIT.
- WAIT:
  - Drives idle outputs.
  - On valid = 1: capture res_match = match, and res_index = match ? match_index : 0; go to DONE.
- DONE:
  - done = 1 for exactly one cycle; busy stays 1 in this cycle.
  - Next cycle: IDLE with busy = 0.
  - res_match, res_index and timeout hold until the next done.
- Timing: start sampled at edge T → first char valid after edge T+1. The last pattern char is driven at cycle T+L+P, or T+P when the string is skipped.
- valid is ignored outside WAIT. start is ignored while busy.
- Reset mid-job: outputs drop to 0 immediately and str_sent is cleared, so the next job always resends the string.
- Char counter is 5 bits and never wraps past the latched length.

Optional Feature:
TIMEOUT_EN
- Defined:
  - A counter runs in WAIT.
  - If TIMEOUT_CYC cycles elapse without valid: enter DONE with timeout = 1, res_match = 0, res_index = 0.
  - str_sent is cleared so the next job resends the string.
  - valid arriving on the same cycle the limit is reached wins; timeout stays 0.
- Undefined: WAIT holds indefinitely until valid; the timeout port is tied to 0.

Test Plan:
- Load string "ABCDE", pattern "CD"; start with send_str = 0 after reset → 5 cycles isstring = 1 with chars 0x41..0x45, then 2 cycles ispattern = 1 with 0x43, 0x44. Engine model returns valid, match = 1, index = 2 → done = 1, res_match = 1, res_index = 2.
- Second job with send_str = 0 and pattern "XY" → no isstring cycles; first ispattern char the cycle after start. Engine returns match = 0 with index = 7 → res_match = 0, res_index = 0.
- str_len = 0 or 33, or pat_len = 9 → start ignored; busy, isstring and ispattern stay 0.
- start and cfg_we pulsed while busy → no restart, buffer unchanged; result matches the first job.
- Reset asserted during SEND_STR → all outputs 0 asynchronously. Next start with send_str = 0 still sends the full string.
- TIMEOUT_EN defined with TIMEOUT_CYC = 16, engine silent → done after 16 WAIT cycles with timeout = 1, res_match = 0, res_index = 0.

Source files
------------

// File: rtl/sme_driver.sv
// Host-side transmitter for the string-matching engine: buffers a string and a pattern,
// streams them as chardata/isstring/ispattern, then returns the engine's result. Option: TIMEOUT_EN.
module sme_driver #(
   parameter int STR_MAX     = 32,
   parameter int PAT_MAX     = 8,
   parameter int TIMEOUT_CYC = 1023
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cfg_we,
   input  logic       cfg_sel,
   input  logic [4:0] cfg_addr,
   input  logic [7:0] cfg_data,
   input  logic [5:0] str_len,
   input  logic [3:0] pat_len,
   input  logic       send_str,
   input  logic       start,
   output logic       busy,
   output logic [7:0] chardata,
   output logic       isstring,
   output logic       ispattern,
   input  logic       valid,
   input  logic       match,
   input  logic [4:0] match_index,
   output logic       done,
   output logic       res_match,
   output logic [4:0] res_index,
   output logic       timeout
);

   typedef enum logic [2:0] {IDLE, SEND_STR, SEND_PAT, WAIT, DONE} state_t;

   state_t     state, state_n;
   logic [4:0] cnt, cnt_n;
   logic [4:0] slast;
   logic [2:0] plast;
   logic       str_sent;
   logic [7:0] chr_n;
   logic       iss_n, isp_n;
   logic       ld, cap, set_sent, len_ok;
   logic [7:0] sbuf [STR_MAX];
   logic [7:0] pbuf [PAT_MAX];

   // Buffers have no reset; contents survive reset and jobs.
   always_ff @(posedge clk) begin
      if (cfg_we && state == IDLE) begin
         if (cfg_sel) pbuf[cfg_addr[2:0]] <= cfg_data;
         else         sbuf[cfg_addr]      <= cfg_data;
      end
   end

   assign len_ok = (str_len != 6'd0) && (str_len <= 6'(STR_MAX)) &&
                   (pat_len != 4'd0) && (pat_len <= 4'(PAT_MAX));

`ifdef TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   logic [TW-1:0] wcnt;
   logic          to_hit;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)               wcnt <= '0;
      else if (state != WAIT)  wcnt <= '0;
      else                     wcnt <= wcnt + 1'b1;
   end
`endif

   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      chr_n    = 8'd0;
      iss_n    = 1'b0;
      isp_n    = 1'b0;
      ld       = 1'b0;
      cap      = 1'b0;
      set_sent = 1'b0;
`ifdef TIMEOUT_EN
      to_hit   = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (start && len_ok) begin
               ld      = 1'b1;
               cnt_n   = 5'd0;
               state_n = (send_str || !str_sent) ? SEND_STR : SEND_PAT;
            end
         end
         SEND_STR: begin
            chr_n = sbuf[cnt];
            iss_n = 1'b1;
            if (cnt == slast) begin
               cnt_n    = 5'd0;
               set_sent = 1'b1;
               state_n  = SEND_PAT;
            end else begin
               cnt_n = cnt + 5'd1;
            end
         end
         SEND_PAT: begin
            chr_n = pbuf[cnt[2:0]];
            isp_n = 1'b1;
            if (cnt[2:0] == plast) begin
               cnt_n   = 5'd0;
               state_n = WAIT;
            end else begin
               cnt_n = cnt + 5'd1;
            end
         end
         WAIT: begin
            // valid on the limit cycle takes priority over the watchdog
            if (valid) begin
               cap     = 1'b1;
               state_n = DONE;
            end
`ifdef TIMEOUT_EN
            else if (wcnt == TW'(TIMEOUT_CYC - 1)) begin
               to_hit  = 1'b1;
               state_n = DONE;
            end
`endif
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= 5'd0;
         slast     <= 5'd0;
         plast     <= 3'd0;
         str_sent  <= 1'b0;
         busy      <= 1'b0;
         chardata  <= 8'd0;
         isstring  <= 1'b0;
         ispattern <= 1'b0;
         done      <= 1'b0;
         res_match <= 1'b0;
         res_index <= 5'd0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         chardata  <= chr_n;
         isstring  <= iss_n;
         ispattern <= isp_n;
         busy      <= (state_n != IDLE);
         done      <= (state_n == DONE);
         if (ld) begin
            slast <= 5'(str_len - 6'd1);
            plast <= 3'(pat_len - 4'd1);
         end
         if (set_sent) str_sent <= 1'b1;
         if (cap) begin
            res_match <= match;
            res_index <= match ? match_index : 5'd0;
         end
`ifdef TIMEOUT_EN
         if (to_hit) begin
            str_sent  <= 1'b0;
            res_match <= 1'b0;
            res_index <= 5'd0;
         end
`endif
      end
   end

`ifdef TIMEOUT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset)       timeout <= 1'b0;
      else if (cap)    timeout <= 1'b0;
      else if (to_hit) timeout <= 1'b1;
   end
`else
   assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_sme_driver.sv
// Directed bench for sme_driver: streaming order/timing, result capture, illegal starts,
// busy lockout, mid-job reset and (with TIMEOUT_EN) the watchdog.
module tb_sme_driver;

   logic       clk = 1'b0;
   logic       reset;
   logic       cfg_we, cfg_sel;
   logic [4:0] cfg_addr;
   logic [7:0] cfg_data;
   logic [5:0] str_len;
   logic [3:0] pat_len;
   logic       send_str, start;
   logic       busy, isstring, ispattern;
   logic [7:0] chardata;
   logic       valid, match;
   logic [4:0] match_index;
   logic       done, res_match, timeout;
   logic [4:0] res_index;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   sme_driver #(.STR_MAX(32), .PAT_MAX(8), .TIMEOUT_CYC(16)) dut (
      .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr),
      .cfg_data(cfg_data), .str_len(str_len), .pat_len(pat_len), .send_str(send_str),
      .start(start), .busy(busy), .chardata(chardata), .isstring(isstring),
      .ispattern(ispattern), .valid(valid), .match(match), .match_index(match_index),
      .done(done), .res_match(res_match), .res_index(res_index), .timeout(timeout)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      if (obs !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic wr(input logic sel, input logic [4:0] a, input logic [7:0] d);
      cfg_we = 1'b1; cfg_sel = sel; cfg_addr = a; cfg_data = d;
      tick();
      cfg_we = 1'b0;
   endtask

   task automatic start_job(input logic [5:0] l, input logic [3:0] p, input logic s);
      str_len = l; pat_len = p; send_str = s; start = 1'b1;
      tick();
      start = 1'b0;
      chk("busy_after_start", busy, 1'b1);
      chk("idle_char_after_start", {isstring, ispattern}, 2'b00);
   endtask

   // n chars from packed vector, char i at [8*i +: 8]
   task automatic stream(input int n, input logic st, input logic [63:0] chars, input string tag);
      for (int i = 0; i < n; i++) begin
         tick();
         chk({tag, "_char"}, chardata, chars[8*i +: 8]);
         chk({tag, "_flags"}, {isstring, ispattern}, {st, ~st});
      end
   endtask

   task automatic engine(input logic m, input logic [4:0] idx,
                         input logic exp_m, input logic [4:0] exp_i);
      valid = 1'b1; match = m; match_index = idx;
      tick();
      valid = 1'b0; match = 1'b0; match_index = 5'd0;
      chk("done_pulse", done, 1'b1);
      chk("busy_in_done", busy, 1'b1);
      chk("flags_in_done", {isstring, ispattern}, 2'b00);
      chk("chardata_idle", chardata, 8'd0);
      chk("res_match", res_match, exp_m);
      chk("res_index", res_index, exp_i);
      chk("timeout_clear", timeout, 1'b0);
      tick();
      chk("done_one_cycle", done, 1'b0);
      chk("busy_drop", busy, 1'b0);
      chk("res_match_hold", res_match, exp_m);
      chk("res_index_hold", res_index, exp_i);
   endtask

   initial begin
      reset = 1'b1; cfg_we = 0; cfg_sel = 0; cfg_addr = 0; cfg_data = 0;
      str_len = 0; pat_len = 0; send_str = 0; start = 0;
      valid = 0; match = 0; match_index = 0;
      tick(); tick();
      chk("rst_busy", busy, 1'b0);
      chk("rst_flags", {isstring, ispattern, done, res_match, timeout}, 5'd0);
      chk("rst_data", {chardata, res_index}, 13'd0);
      reset = 1'b0;
      tick();

      // string "ABCDE", pattern "CD"
      wr(0, 0, 8'h41); wr(0, 1, 8'h42); wr(0, 2, 8'h43); wr(0, 3, 8'h44); wr(0, 4, 8'h45);
      wr(1, 0, 8'h43); wr(1, 1, 8'h44);

      // Job 1: send_str=0 but string never sent, so string goes out
      start_job(6'd5, 4'd2, 1'b0);
      stream(5, 1'b1, 64'h45_44_43_42_41, "j1_str");
      stream(2, 1'b0, 64'h44_43, "j1_pat");
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("wait_no_done", {done, isstring, ispattern}, 3'b000);
         chk("wait_busy", busy, 1'b1);
      end
      engine(1'b1, 5'd2, 1'b1, 5'd2);

      // Job 2: string skipped, pattern "XY", no match with stray index
      wr(1, 0, 8'h58); wr(1, 1, 8'h59);
      start_job(6'd5, 4'd2, 1'b0);
      stream(2, 1'b0, 64'h59_58, "j2_pat");
      engine(1'b0, 5'd7, 1'b0, 5'd0);

      // Illegal lengths: start ignored
      start_job_bad(6'd0, 4'd2);
      start_job_bad(6'd33, 4'd2);
      start_job_bad(6'd5, 4'd9);
      start_job_bad(6'd5, 4'd0);

      // Job 3: start and cfg_we while busy are ignored
      start_job(6'd5, 4'd2, 1'b1);
      start = 1'b1; str_len = 6'd3; cfg_we = 1'b1; cfg_sel = 1'b1; cfg_addr = 5'd0; cfg_data = 8'h5A;
      stream(5, 1'b1, 64'h45_44_43_42_41, "j3_str");
      start = 1'b0; cfg_we = 1'b0;
      stream(2, 1'b0, 64'h59_58, "j3_pat");
      engine(1'b1, 5'd31, 1'b1, 5'd31);
      tick();
      chk("no_restart", {busy, isstring, ispattern}, 3'b000);

      // Reset during SEND_STR
      start_job(6'd5, 4'd2, 1'b1);
      stream(2, 1'b1, 64'h42_41, "j4_str");
      reset = 1'b1;
      #1;
      chk("async_rst_flags", {busy, isstring, ispattern, done}, 4'd0);
      chk("async_rst_char", chardata, 8'd0);
      tick();
      reset = 1'b0;
      tick();
      start_job(6'd5, 4'd2, 1'b0);
      stream(5, 1'b1, 64'h45_44_43_42_41, "j5_str");
      stream(2, 1'b0, 64'h59_58, "j5_pat");
      engine(1'b1, 5'd4, 1'b1, 5'd4);

`ifdef TIMEOUT_EN
      // Silent engine: watchdog fires after 16 WAIT cycles
      start_job(6'd5, 4'd1, 1'b0);
      stream(1, 1'b0, 64'h58, "j6_pat");
      for (int i = 0; i < 15; i++) begin
         tick();
         chk("to_not_yet", done, 1'b0);
      end
      tick();
      chk("to_done", done, 1'b1);
      chk("to_flag", timeout, 1'b1);
      chk("to_res", {res_match, res_index}, 6'd0);
      tick();
      chk("to_idle", {busy, done, timeout}, 3'b001);
      // string must be resent after a timeout
      start_job(6'd5, 4'd1, 1'b0);
      stream(5, 1'b1, 64'h45_44_43_42_41, "j7_str");
      stream(1, 1'b0, 64'h58, "j7_pat");
      engine(1'b0, 5'd3, 1'b0, 5'd0);
`else
      chk("timeout_tied", timeout, 1'b0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   task automatic start_job_bad(input logic [5:0] l, input logic [3:0] p);
      str_len = l; pat_len = p; send_str = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      chk("bad_busy", busy, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("bad_flags", {busy, isstring, ispattern}, 3'b000);
      end
   endtask

endmodule
